// File: rtl/sequencer_if.sv
// ============================================================================
// Module   : sequencer_if
// Brief    : Control/status bundle between the sequencer and the datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sequencer_if #(
  parameter int OP_W = 3
);
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic            mem_ready;
  logic            ACC_bus;
  logic            load_ACC;
  logic            ALU_ACC;
  logic            ALU_add;
  logic            ALU_sub;
  logic            ALU_xor;
  logic            PC_bus;
  logic            load_PC;
  logic            INC_PC;
  logic            load_IR;
  logic            Addr_bus;
  logic            load_MAR;
  logic            load_MDR;
  logic            MDR_bus;
  logic            CS;
  logic            R_NW;
  logic            halted;

  modport master (
    input  op, z_flag, mem_ready,
    output ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor,
           PC_bus, load_PC, INC_PC, load_IR, Addr_bus,
           load_MAR, load_MDR, MDR_bus, CS, R_NW, halted
  );

  modport slave (
    output op, z_flag, mem_ready,
    input  ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor,
           PC_bus, load_PC, INC_PC, load_IR, Addr_bus,
           load_MAR, load_MDR, MDR_bus, CS, R_NW, halted
  );
endinterface

`default_nettype wire

// File: rtl/sequencer.sv
// ============================================================================
// Module   : sequencer
// Brief    : Fetch/decode/execute control FSM for a single-accumulator CPU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sequencer #(
  parameter int OP_W = 3
) (
  input  logic       clock,
  input  logic       n_reset,
  sequencer_if.master bus
);

  localparam logic [OP_W-1:0] c_OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] c_OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] c_OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] c_OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] c_OP_XOR   = 3'b100;
  localparam logic [OP_W-1:0] c_OP_BNE   = 3'b101;
  localparam logic [OP_W-1:0] c_OP_BEQ   = 3'b110;
  localparam logic [OP_W-1:0] c_OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH_ADDR = 3'd0,
    S_FETCH_MEM  = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC_ADDR  = 3'd3,
    S_EXEC_MEM   = 3'd4,
    S_WRITE      = 3'd5,
    S_EXEC_ALU   = 3'd6,
    S_HALT       = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [OP_W-1:0] w_op;

  assign w_op = bus.op;

  // Async reset parks the FSM in FETCH_ADDR so outputs follow at once.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_FETCH_ADDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    bus.ACC_bus  = 1'b0;
    bus.load_ACC = 1'b0;
    bus.ALU_ACC  = 1'b0;
    bus.ALU_add  = 1'b0;
    bus.ALU_sub  = 1'b0;
    bus.ALU_xor  = 1'b0;
    bus.PC_bus   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.load_IR  = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.load_MAR = 1'b0;
    bus.load_MDR = 1'b0;
    bus.MDR_bus  = 1'b0;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b0;
    bus.halted   = 1'b0;

    case (r_state)
      S_FETCH_ADDR: begin
        bus.PC_bus   = 1'b1;
        bus.load_MAR = 1'b1;
        bus.INC_PC   = 1'b1;
        w_next_state = S_FETCH_MEM;
      end
      S_FETCH_MEM: begin
        bus.CS   = 1'b1;
        bus.R_NW = 1'b1;
        if (bus.mem_ready) begin
          bus.load_MDR = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.MDR_bus  = 1'b1;
        bus.load_IR  = 1'b1;
        w_next_state = S_EXEC_ADDR;
      end
      S_EXEC_ADDR: begin
        bus.Addr_bus = 1'b1;
        case (w_op)
          c_OP_BNE: begin
            bus.load_PC  = ~bus.z_flag;
            w_next_state = S_FETCH_ADDR;
          end
          c_OP_BEQ: begin
            bus.load_PC  = bus.z_flag;
            w_next_state = S_FETCH_ADDR;
          end
          c_OP_HALT: begin
            w_next_state = S_HALT;
          end
          default: begin
            bus.load_MAR = 1'b1;
            w_next_state = S_EXEC_MEM;
          end
        endcase
      end
      S_EXEC_MEM: begin
        // STORE stages the accumulator into MDR; no memory cycle yet.
        if (w_op == c_OP_STORE) begin
          bus.ACC_bus  = 1'b1;
          bus.load_MDR = 1'b1;
          w_next_state = S_WRITE;
        end else begin
          bus.CS   = 1'b1;
          bus.R_NW = 1'b1;
          if (bus.mem_ready) begin
            bus.load_MDR = 1'b1;
            w_next_state = S_EXEC_ALU;
          end
        end
      end
      S_WRITE: begin
        bus.CS = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = S_FETCH_ADDR;
        end
      end
      S_EXEC_ALU: begin
        bus.MDR_bus  = 1'b1;
        bus.load_ACC = 1'b1;
        bus.ALU_ACC  = (w_op != c_OP_LOAD);
        bus.ALU_add  = (w_op == c_OP_ADD);
        bus.ALU_sub  = (w_op == c_OP_SUB);
        bus.ALU_xor  = (w_op == c_OP_XOR);
        w_next_state = S_FETCH_ADDR;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: begin
        w_next_state = S_FETCH_ADDR;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sequencer.sv
// ============================================================================
// Module   : tb_sequencer
// Brief    : Directed bench; instruction-level model expands each instruction
//            into its expected per-cycle control word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sequencer;

  localparam logic [16:0] M_ACCB  = 17'h10000;
  localparam logic [16:0] M_LACC  = 17'h08000;
  localparam logic [16:0] M_AACC  = 17'h04000;
  localparam logic [16:0] M_ADD   = 17'h02000;
  localparam logic [16:0] M_SUB   = 17'h01000;
  localparam logic [16:0] M_XOR   = 17'h00800;
  localparam logic [16:0] M_PCB   = 17'h00400;
  localparam logic [16:0] M_LPC   = 17'h00200;
  localparam logic [16:0] M_INC   = 17'h00100;
  localparam logic [16:0] M_LIR   = 17'h00080;
  localparam logic [16:0] M_ADRB  = 17'h00040;
  localparam logic [16:0] M_LMAR  = 17'h00020;
  localparam logic [16:0] M_LMDR  = 17'h00010;
  localparam logic [16:0] M_MDRB  = 17'h00008;
  localparam logic [16:0] M_CS    = 17'h00004;
  localparam logic [16:0] M_RNW   = 17'h00002;
  localparam logic [16:0] M_HALT  = 17'h00001;
  localparam logic [16:0] W_FA    = M_PCB | M_LMAR | M_INC;

  localparam logic [2:0] LOAD = 3'd0, STORE = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         XOR = 3'd4, BNE = 3'd5, BEQ = 3'd6, HALT = 3'd7;

  typedef struct packed {
    logic        mr;
    logic [2:0]  op;
    logic        z;
    logic [16:0] exp;
  } rec_t;

  logic  clock = 1'b0;
  logic  n_reset = 1'b1;
  rec_t  prog[$];
  rec_t  cur;
  logic  cur_valid = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  sequencer_if #(.OP_W(3)) ifc ();

  sequencer #(.OP_W(3)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (ifc)
  );

  always #5 clock = ~clock;

  logic [16:0] got;
  assign got = {ifc.ACC_bus, ifc.load_ACC, ifc.ALU_ACC, ifc.ALU_add, ifc.ALU_sub,
                ifc.ALU_xor, ifc.PC_bus, ifc.load_PC, ifc.INC_PC, ifc.load_IR,
                ifc.Addr_bus, ifc.load_MAR, ifc.load_MDR, ifc.MDR_bus, ifc.CS,
                ifc.R_NW, ifc.halted};

  task automatic chk(input string name, input logic [16:0] a, input logic [16:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, a, e);
    end
  endtask

  task automatic chk_excl(input string name);
    int n;
    n = int'(ifc.ACC_bus) + int'(ifc.PC_bus) + int'(ifc.Addr_bus) + int'(ifc.MDR_bus);
    checks++;
    if (n > 1) begin
      errors++;
      $display("FAIL %s bus drivers=%0d exp<=1", name, n);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic void push(input logic mr, input logic [2:0] op,
                               input logic z, input logic [16:0] e);
    rec_t r;
    r.mr = mr; r.op = op; r.z = z; r.exp = e;
    prog.push_back(r);
  endfunction

  // Expand one instruction into cycles; fw/ew/ww are memory wait counts.
  function automatic void add_instr(input logic [2:0] op, input logic z,
                                    input int fw, input int ew, input int ww,
                                    input int hc);
    logic [16:0] e;
    push(rb(), rop(), rb(), W_FA);
    for (int i = 0; i < fw; i++) push(1'b0, rop(), rb(), M_CS | M_RNW);
    push(1'b1, rop(), rb(), M_CS | M_RNW | M_LMDR);
    push(rb(), rop(), rb(), M_MDRB | M_LIR);
    e = M_ADRB;
    if (op == BNE) e |= (z ? 17'h0 : M_LPC);
    else if (op == BEQ) e |= (z ? M_LPC : 17'h0);
    else if (op != HALT) e |= M_LMAR;
    push(rb(), op, z, e);
    if (op == BNE || op == BEQ) return;
    if (op == HALT) begin
      for (int i = 0; i < hc; i++) push(rb(), rop(), rb(), M_HALT);
      return;
    end
    if (op == STORE) begin
      push(rb(), op, rb(), M_ACCB | M_LMDR);
      for (int i = 0; i < ww; i++) push(1'b0, op, rb(), M_CS);
      push(1'b1, op, rb(), M_CS);
      return;
    end
    for (int i = 0; i < ew; i++) push(1'b0, op, rb(), M_CS | M_RNW);
    push(1'b1, op, rb(), M_CS | M_RNW | M_LMDR);
    e = M_MDRB | M_LACC;
    if (op != LOAD) e |= M_AACC;
    if (op == ADD)  e |= M_ADD;
    if (op == SUB)  e |= M_SUB;
    if (op == XOR)  e |= M_XOR;
    push(rb(), op, rb(), e);
  endfunction

  // Applies n records, one per cycle; releases reset alongside the first.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      n_reset       = 1'b1;
      ifc.mem_ready = prog[i].mr;
      ifc.op        = prog[i].op;
      ifc.z_flag    = prog[i].z;
      cur           = prog[i];
      cur_valid     = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (cur_valid) begin
      chk($sformatf("cycle%0d", cyc), got, cur.exp);
      chk_excl($sformatf("excl%0d", cyc));
      cyc++;
    end
  end

  initial begin
    int base;
    int cnt;
    ifc.op = 3'd0; ifc.z_flag = 1'b0; ifc.mem_ready = 1'b0;
    #1 n_reset = 1'b0;
    #2;
    chk("reset_outputs", got, W_FA);

    // Model pins against hand-derived figures.
    prog.delete();
    add_instr(ADD, 1'b0, 0, 0, 0, 0);
    chk("add_len", 17'(prog.size()), 17'd6);
    chk("add_alu", prog[5].exp, 17'h0E008);
    base = prog.size();
    add_instr(STORE, 1'b0, 0, 0, 3, 0);
    chk("store_len", 17'(prog.size() - base), 17'd9);
    cnt = 0;
    for (int i = base; i < prog.size(); i++)
      if (prog[i].exp == M_CS) cnt++;
    chk("store_write_cycles", 17'(cnt), 17'd4);
    base = prog.size();
    add_instr(BNE, 1'b0, 0, 0, 0, 0);
    chk("bne_len", 17'(prog.size() - base), 17'd4);
    chk("bne_z0_pc", prog[base + 3].exp, 17'h00240);
    base = prog.size();
    add_instr(BNE, 1'b1, 0, 0, 0, 0);
    chk("bne_z1_pc", prog[base + 3].exp, 17'h00040);
    base = prog.size();
    add_instr(LOAD, 1'b0, 0, 0, 0, 0);
    chk("load_alu", prog[base + 5].exp, 17'h08008);
    add_instr(BEQ, 1'b1, 0, 0, 0, 0);
    add_instr(BEQ, 1'b0, 0, 0, 0, 0);
    add_instr(LOAD, 1'b1, 2, 1, 0, 0);
    add_instr(SUB, 1'b0, 1, 2, 0, 0);
    add_instr(XOR, 1'b1, 0, 0, 0, 0);
    add_instr(STORE, 1'b1, 1, 0, 0, 0);
    run(prog.size());

    // Reset while a LOAD waits in EXEC_MEM, between clock edges.
    prog.delete();
    add_instr(LOAD, 1'b0, 0, 5, 0, 0);
    run(6);
    @(negedge clock);
    #2;
    cur_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    chk("rst_async", got, W_FA);
    chk_excl("rst_async_excl");
    ifc.mem_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_hold", got, W_FA);

    // HALT for 20+ clocks, then reset out of it.
    prog.delete();
    add_instr(HALT, 1'b0, 0, 0, 0, 21);
    run(prog.size());
    @(negedge clock);
    #2;
    cur_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    chk("halt_reset", got, W_FA);
    chk("halt_cleared", {16'h0, ifc.halted}, 17'h0);

    prog.delete();
    add_instr(ADD, 1'b0, 0, 0, 0, 0);
    run(prog.size());
    @(posedge clock);
    #1;
    cur_valid = 1'b0;
    chk("add_return_fa", got, W_FA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
